// File: rtl/prn_line_shifter_if.sv
// Signal bundle between the print-data converter / line controller and the
// print-head line shifter.
interface prn_line_shifter_if;
    // Read side is a fixed-latency strobe with no backpressure: rd_req is high
    // for one cycle, the converter presents prn_data in the following cycle and
    // the shifter samples it at the end of that cycle.
    logic        line_start;
    logic        rd_req;
    logic [15:0] prn_data;
    logic        head_sclk;
    logic [3:0]  head_sdata;
    logic        head_latch;
    logic        busy;
    logic        line_done;
    logic        overrun;

    modport master (
        output line_start, prn_data,
        input  rd_req, head_sclk, head_sdata, head_latch, busy, line_done, overrun
    );

    modport slave (
        input  line_start, prn_data,
        output rd_req, head_sclk, head_sdata, head_latch, busy, line_done, overrun
    );
endinterface

// File: rtl/prn_line_shifter.sv
// Pulls LINE_WORDS 16-bit words from the converter and shifts them MSB-first
// as four 4-bit lanes onto the print head, then pulses the head latch.
module prn_line_shifter #(
    parameter int LINE_WORDS = 160,
    parameter int CLK_DIV    = 2,
    parameter int LATCH_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    prn_line_shifter_if.slave bus,
    output logic [2:0]        o_dbg_state
);
    localparam int PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int WD_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int LT_W = (LATCH_W > 1) ? $clog2(LATCH_W) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(LINE_WORDS - 1);
    localparam logic [LT_W-1:0] LT_LAST = LT_W'(LATCH_W - 1);
    localparam logic MULTI_WORD = (LINE_WORDS > 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_SHIFT = 3'd3;
    localparam logic [2:0] ST_LATCH = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    logic [2:0]      r_state;
    logic [15:0]     r_sr;
    logic [15:0]     r_hold;
    logic [WD_W-1:0] r_word;
    logic [1:0]      r_bit;
    logic [PH_W-1:0] r_phase;
    logic            r_sclk_hi;
    logic [LT_W-1:0] r_lat_cnt;
    logic            r_rd_d;
    logic            r_overrun;

    logic        w_in_shift;
    logic        w_phase_end;
    logic        w_bit_end;
    logic        w_word_end;
    logic        w_line_end;
    logic        w_word_first;
    logic        w_rd_req;
    logic [15:0] w_sr_shifted;

    assign w_in_shift   = (r_state == ST_SHIFT);
    assign w_phase_end  = (r_phase == PH_LAST);
    assign w_bit_end    = w_in_shift && r_sclk_hi && w_phase_end;
    assign w_word_end   = w_bit_end && (r_bit == 2'd3);
    assign w_line_end   = w_word_end && (r_word == WD_LAST);
    assign w_word_first = w_in_shift && (r_bit == 2'd0) && !r_sclk_hi && (r_phase == '0);

    // Word 0 is fetched in FETCH and word 1 in LOAD, so the in-shift prefetch
    // only starts from word 1 and stops once the last word has been requested.
    assign w_rd_req = !rst && ((r_state == ST_FETCH) ||
                               ((r_state == ST_LOAD) && MULTI_WORD) ||
                               (w_word_first && (r_word != '0) && (r_word != WD_LAST)));

    assign w_sr_shifted = {r_sr[14:12], 1'b0, r_sr[10:8], 1'b0,
                           r_sr[6:4],   1'b0, r_sr[2:0],  1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_sr      <= '0;
            r_hold    <= '0;
            r_word    <= '0;
            r_bit     <= '0;
            r_phase   <= '0;
            r_sclk_hi <= 1'b0;
            r_lat_cnt <= '0;
            r_rd_d    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= bus.line_start && (r_state != ST_IDLE);
            r_rd_d    <= w_rd_req;
            // LOAD takes word 0 straight into the shifter; later reads go to hold.
            if (r_rd_d && (r_state != ST_LOAD)) begin
                r_hold <= bus.prn_data;
            end
            case (r_state)
                ST_IDLE: begin
                    if (bus.line_start) begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_sr      <= bus.prn_data;
                    r_word    <= '0;
                    r_bit     <= '0;
                    r_phase   <= '0;
                    r_sclk_hi <= 1'b0;
                    r_state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (w_phase_end) begin
                        r_phase   <= '0;
                        r_sclk_hi <= ~r_sclk_hi;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                    if (w_bit_end) begin
                        r_bit <= r_bit + 2'd1;
                        if (w_word_end) begin
                            r_sr   <= r_hold;
                            r_word <= r_word + 1'b1;
                        end else begin
                            r_sr <= w_sr_shifted;
                        end
                        if (w_line_end) begin
                            r_word  <= '0;
                            r_state <= ST_LATCH;
                        end
                    end
                end
                ST_LATCH: begin
                    if (r_lat_cnt == LT_LAST) begin
                        r_lat_cnt <= '0;
                        r_state   <= ST_DONE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_req     = w_rd_req;
    assign bus.head_sclk  = w_in_shift && r_sclk_hi;
    assign bus.head_sdata = w_in_shift ? {r_sr[15], r_sr[11], r_sr[7], r_sr[3]} : 4'd0;
    assign bus.head_latch = (r_state == ST_LATCH);
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.line_done  = (r_state == ST_DONE);
    assign bus.overrun    = r_overrun;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_prn_line_shifter.sv
// Bench for prn_line_shifter: three configurations, a converter model feeding
// queued words (random bus garbage otherwise) and a head-bit scoreboard.
module tb_prn_line_shifter;
    localparam int NW_TAB  [3] = '{2, 4, 1};
    localparam int DIV_TAB [3] = '{2, 1, 1};
    localparam int LW_TAB  [3] = '{4, 4, 1};

    logic        clk = 1'b0;
    logic [2:0]  rst_v;
    logic [2:0]  line_start_v;
    logic [15:0] prn_data_drv;
    wire  [2:0]  rd_req_v;
    wire  [2:0]  sclk_v;
    wire  [2:0]  latch_v;
    wire  [2:0]  busy_v;
    wire  [2:0]  done_v;
    wire  [2:0]  ovr_v;
    wire  [3:0]  sdata_v [3];
    wire  [2:0]  dbg_v [3];

    int sel;
    int div_sel;
    logic mon_en;

    logic [3:0]  exp_q [$];
    logic [15:0] word_q [$];
    int rd_cyc_q [$];

    int cyc = 0;
    int t0;
    int rd_cnt, rise_cnt, latch_cnt, latch_first, done_cnt, done_cyc;
    int ovr_cnt, ovr_cyc, busy_cnt, last_rise;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        prn_line_shifter_if bus ();
        assign bus.line_start = line_start_v[g];
        assign bus.prn_data   = prn_data_drv;
        assign rd_req_v[g]    = bus.rd_req;
        assign sclk_v[g]      = bus.head_sclk;
        assign latch_v[g]     = bus.head_latch;
        assign busy_v[g]      = bus.busy;
        assign done_v[g]      = bus.line_done;
        assign ovr_v[g]       = bus.overrun;
        assign sdata_v[g]     = bus.head_sdata;

        prn_line_shifter #(
            .LINE_WORDS (NW_TAB[g]),
            .CLK_DIV    (DIV_TAB[g]),
            .LATCH_W    (LW_TAB[g])
        ) u_dut (
            .clk         (clk),
            .rst         (rst_v[g]),
            .bus         (bus.slave),
            .o_dbg_state (dbg_v[g])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [15:0] w);
        for (int b = 3; b >= 0; b--) begin
            exp_q.push_back({w[12+b], w[8+b], w[4+b], w[b]});
        end
    endtask

    // Converter model plus head monitor for the selected instance.
    initial begin : p_monitor
        logic        cap_pend;
        logic        sclk_prev;
        logic [15:0] w;
        cap_pend  = 1'b0;
        sclk_prev = 1'b0;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (cap_pend) begin
                if (word_q.size() > 0) begin
                    w = word_q.pop_front();
                    push_exp(w);
                end else begin
                    w = 16'($urandom);
                end
                prn_data_drv = w;
            end else begin
                prn_data_drv = 16'($urandom);
            end
            cap_pend = rd_req_v[sel];
            if (rd_req_v[sel]) begin
                rd_cnt++;
                rd_cyc_q.push_back(cyc);
            end
            if (sclk_v[sel] && !sclk_prev) begin
                rise_cnt++;
                check_eq("sb_has_bit", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check_eq("head_sdata", sdata_v[sel], exp_q.pop_front());
                if (last_rise >= 0) check_eq("sclk_period", cyc - last_rise, 2 * div_sel);
                last_rise = cyc;
            end
            sclk_prev = sclk_v[sel];
            if (latch_v[sel]) begin
                if (latch_cnt == 0) latch_first = cyc;
                latch_cnt++;
            end
            if (done_v[sel]) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (ovr_v[sel]) begin
                ovr_cnt++;
                ovr_cyc = cyc;
            end
            if (busy_v[sel]) begin
                busy_cnt++;
            end else begin
                check_eq("idle_sdata", sdata_v[sel], 0);
                check_eq("idle_sclk", sclk_v[sel], 0);
            end
        end
    end

    task automatic check_zero_outputs(input int s);
        check_eq("zero_rd_req", rd_req_v[s], 0);
        check_eq("zero_sclk", sclk_v[s], 0);
        check_eq("zero_sdata", sdata_v[s], 0);
        check_eq("zero_latch", latch_v[s], 0);
        check_eq("zero_busy", busy_v[s], 0);
        check_eq("zero_done", done_v[s], 0);
        check_eq("zero_overrun", ovr_v[s], 0);
        check_eq("zero_state", dbg_v[s], 0);
    endtask

    task automatic start_line();
        rd_cnt = 0; rise_cnt = 0; latch_cnt = 0; latch_first = -1;
        done_cnt = 0; done_cyc = -1; ovr_cnt = 0; ovr_cyc = -1;
        busy_cnt = 0; last_rise = -1;
        rd_cyc_q.delete();
        t0 = cyc;
        line_start_v[sel] = 1'b1;
        @(negedge clk);
        line_start_v[sel] = 1'b0;
    endtask

    task automatic pulse_start();
        line_start_v[sel] = 1'b1;
        @(negedge clk);
        line_start_v[sel] = 1'b0;
    endtask

    task automatic goto_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget && done_cnt == 0; k++) @(negedge clk);
        check_eq("line_done_in_budget", 32'(done_cnt != 0), 1);
    endtask

    task automatic load_random(input int n);
        for (int i = 0; i < n; i++) word_q.push_back(16'($urandom));
    endtask

    task automatic check_line(input int n, input int d, input int l);
        int sh;
        sh = 8 * n * d;
        check_eq("rd_req_count", rd_cnt, n);
        check_eq("sclk_rises", rise_cnt, 4 * n);
        check_eq("latch_cycles", latch_cnt, l);
        check_eq("latch_start", latch_first, t0 + 3 + sh);
        check_eq("done_cycle", done_cyc, t0 + 3 + sh + l);
        check_eq("done_count", done_cnt, 1);
        check_eq("busy_cycles", busy_cnt, 3 + sh + l);
        check_eq("sb_drained", exp_q.size(), 0);
        check_eq("words_used", word_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_v        = '1;
        line_start_v = '0;
        prn_data_drv = '0;
        mon_en       = 1'b0;
        sel          = 0;
        div_sel      = 2;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) check_zero_outputs(s);
        rst_v  = '0;
        mon_en = 1'b1;
        @(negedge clk);

        // Single line, known words.
        sel = 0; div_sel = 2;
        word_q.push_back(16'hA5C3);
        word_q.push_back(16'h0F1E);
        start_line();
        wait_done(80);
        goto_cyc(t0 + 43);
        check_line(2, 2, 4);
        check_eq("ovr_none", ovr_cnt, 0);
        if (rd_cyc_q.size() >= 2) begin
            check_eq("rd_req_first", rd_cyc_q[0], t0 + 1);
            check_eq("rd_req_second", rd_cyc_q[1], t0 + 2);
        end

        // Overrun mid-line.
        load_random(2);
        start_line();
        goto_cyc(t0 + 10);
        pulse_start();
        wait_done(80);
        goto_cyc(t0 + 43);
        check_line(2, 2, 4);
        check_eq("ovr_mid_count", ovr_cnt, 1);
        check_eq("ovr_mid_cycle", ovr_cyc, t0 + 11);

        // line_start in the DONE cycle.
        load_random(2);
        start_line();
        goto_cyc(t0 + 39);
        pulse_start();
        goto_cyc(t0 + 46);
        check_line(2, 2, 4);
        check_eq("ovr_done_count", ovr_cnt, 1);
        check_eq("ovr_done_cycle", ovr_cyc, t0 + 40);

        // Reset during word 1.
        load_random(2);
        start_line();
        goto_cyc(t0 + 21);
        rst_v[0] = 1'b1;
        @(negedge clk);
        check_zero_outputs(0);
        rst_v[0] = 1'b0;
        repeat (60) @(negedge clk);
        check_eq("rst_no_latch", latch_cnt, 0);
        check_eq("rst_no_done", done_cnt, 0);
        check_eq("rst_rd_count", rd_cnt, 2);
        exp_q.delete();
        word_q.delete();
        load_random(2);
        start_line();
        wait_done(80);
        goto_cyc(t0 + 43);
        check_line(2, 2, 4);

        // Back-to-back lines at minimum spacing, CLK_DIV=1, 4 words.
        sel = 1; div_sel = 1;
        word_q.push_back(16'h1111);
        word_q.push_back(16'h2222);
        word_q.push_back(16'h3333);
        word_q.push_back(16'h4444);
        start_line();
        wait_done(80);
        goto_cyc(t0 + 39);
        @(negedge clk);
        check_line(4, 1, 4);
        load_random(4);
        start_line();
        wait_done(80);
        goto_cyc(t0 + 44);
        check_line(4, 1, 4);
        check_eq("b2b_no_overrun", ovr_cnt, 0);

        // Minimum configuration.
        sel = 2; div_sel = 1;
        load_random(1);
        start_line();
        wait_done(40);
        goto_cyc(t0 + 16);
        check_line(1, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
